// File: rtl/stopwatch_bcd_if.sv
// Button inputs and display outputs for the stopwatch_bcd block.
// The stopwatch side connects through the slave modport; the board or
// bench side that owns the buttons and reads the display uses master.
interface stopwatch_bcd_if;
  logic       BTN_SS;
  logic       BTN_CLR;
  logic [3:0] DIG3;
  logic [3:0] DIG2;
  logic [3:0] DIG1;
  logic [3:0] DIG0;
  logic [3:0] DP;
  logic [3:0] EN;
  logic       RUNNING;

  modport master (
    output BTN_SS, BTN_CLR,
    input  DIG3, DIG2, DIG1, DIG0, DP, EN, RUNNING
  );

  modport slave (
    input  BTN_SS, BTN_CLR,
    output DIG3, DIG2, DIG1, DIG0, DP, EN, RUNNING
  );
endinterface

// File: rtl/stopwatch_bcd.sv
// stopwatch_bcd: SS.hh stopwatch with start/stop and clear buttons.
// A prescaler divides CLK down to a 100 Hz tick that advances a four-digit
// cascaded BCD counter; the count saturates at 99.99 and stops there.
// Build option: define STOPWATCH_LZB_EN to blank the tens-of-seconds digit
// while it is zero; without it all four digit enables are constant high.
module stopwatch_bcd #(
  parameter logic [18:0] CNTMAX = 19'd500000 - 19'd1
) (
  input  logic           CLK,
  input  logic           nRST,
  stopwatch_bcd_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  state_t      state_q, state_d;
  logic [2:0]  ss_sync_q, ss_sync_d;
  logic [2:0]  clr_sync_q, clr_sync_d;
  logic [1:0]  fill_q, fill_d;
  logic [18:0] presc_q, presc_d;
  logic [3:0]  dig_q [4];
  logic [3:0]  dig_d [4];
  logic [3:0]  dig_inc [4];
  logic [4:0]  carry;
  logic        ss_p, clr_p, tick, all_nines, edges_armed;

  // Two synchronizer flops then one history flop per button; fill_q
  // counts the first three post-reset samples so that a button already
  // held through reset cannot masquerade as a fresh press.
  always_comb begin
    ss_sync_d  = {ss_sync_q[1:0], bus.BTN_SS};
    clr_sync_d = {clr_sync_q[1:0], bus.BTN_CLR};
    fill_d     = (fill_q == 2'd3) ? fill_q : fill_q + 2'd1;
  end

  assign edges_armed = (fill_q == 2'd3);
  assign ss_p  = ss_sync_q[1]  & ~ss_sync_q[2]  & edges_armed;
  assign clr_p = clr_sync_q[1] & ~clr_sync_q[2] & edges_armed;
  assign tick  = (state_q == RUN) && (presc_q == CNTMAX);

  // Ripple-carry BCD incrementer; carry[4] is set only when all digits are 9.
  assign carry[0] = 1'b1;
  for (genvar gi = 0; gi < 4; gi++) begin : g_digit
    assign dig_inc[gi]  = carry[gi] ? ((dig_q[gi] == 4'd9) ? 4'd0 : dig_q[gi] + 4'd1)
                                    : dig_q[gi];
    assign carry[gi+1]  = carry[gi] & (dig_q[gi] == 4'd9);
  end
  assign all_nines = carry[4];

  // Next state, prescaler and digits; clear beats start/stop in every state.
  always_comb begin
    state_d = state_q;
    presc_d = 19'd0;
    dig_d   = dig_q;
    if (clr_p) begin
      state_d = IDLE;
      dig_d   = '{default: 4'd0};
    end else begin
      unique case (state_q)
        IDLE: begin
          if (ss_p) state_d = RUN;
        end
        RUN: begin
          if (tick) begin
            if (all_nines) begin
              state_d = STOP;
            end else begin
              dig_d = dig_inc;
            end
          end else begin
            presc_d = presc_q + 19'd1;
          end
          if (ss_p) begin
            state_d = STOP;
            presc_d = 19'd0;
          end
        end
        STOP: begin
          if (ss_p && !all_nines) state_d = RUN;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // All state registers, cleared by a low nRST at the clock edge.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q    <= IDLE;
      ss_sync_q  <= 3'b000;
      clr_sync_q <= 3'b000;
      fill_q     <= 2'd0;
      presc_q    <= 19'd0;
      dig_q      <= '{default: 4'd0};
    end else begin
      state_q    <= state_d;
      ss_sync_q  <= ss_sync_d;
      clr_sync_q <= clr_sync_d;
      fill_q     <= fill_d;
      presc_q    <= presc_d;
      dig_q      <= dig_d;
    end
  end

  assign bus.DIG0    = dig_q[0];
  assign bus.DIG1    = dig_q[1];
  assign bus.DIG2    = dig_q[2];
  assign bus.DIG3    = dig_q[3];
  assign bus.DP      = 4'b0100;
  assign bus.RUNNING = (state_q == RUN);
`ifdef STOPWATCH_LZB_EN
  assign bus.EN      = {(dig_q[3] != 4'd0), 3'b111};
`else
  assign bus.EN      = 4'b1111;
`endif

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Directed bench for stopwatch_bcd. A CNTMAX=9 instance covers reset,
// start latency, carries, stop/resume, clear and digit blanking; a
// CNTMAX=0 instance reaches 99.99 quickly for the saturation behaviour.
module tb_stopwatch_bcd;

  logic clk;
  logic nrst;
  int   checks = 0;
  int   errors = 0;

`ifdef STOPWATCH_LZB_EN
  localparam logic [3:0] EN_LEAD_ZERO = 4'b0111;
`else
  localparam logic [3:0] EN_LEAD_ZERO = 4'b1111;
`endif

  stopwatch_bcd_if sw_if ();
  stopwatch_bcd_if fw_if ();

  stopwatch_bcd #(.CNTMAX(19'd9)) u_dut (
    .CLK  (clk),
    .nRST (nrst),
    .bus  (sw_if)
  );

  stopwatch_bcd #(.CNTMAX(19'd0)) u_dut_fast (
    .CLK  (clk),
    .nRST (nrst),
    .bus  (fw_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [15:0] cur_val(input bit fast);
    if (fast) return {fw_if.DIG3, fw_if.DIG2, fw_if.DIG1, fw_if.DIG0};
    return {sw_if.DIG3, sw_if.DIG2, sw_if.DIG1, sw_if.DIG0};
  endfunction

  function automatic logic cur_run(input bit fast);
    return fast ? fw_if.RUNNING : sw_if.RUNNING;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic wait_val(input bit fast, input logic [15:0] target, input int limit,
                          input string tag);
    int n = 0;
    while (cur_val(fast) !== target && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(tag, {16'd0, cur_val(fast)}, {16'd0, target});
  endtask

  task automatic wait_run(input bit fast, input logic level, input string tag);
    int n = 0;
    while (cur_run(fast) !== level && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, cur_run(fast)}, {31'd0, level});
  endtask

  // Cycles from now until the displayed count next changes.
  task automatic cycles_to_change(input bit fast, output int n);
    logic [15:0] start;
    start = cur_val(fast);
    n = 0;
    while (cur_val(fast) === start && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n;
    sw_if.BTN_SS = 1'b1; sw_if.BTN_CLR = 1'b1;
    fw_if.BTN_SS = 1'b1; fw_if.BTN_CLR = 1'b1;
    nrst = 1'b0;

    // Reset with both buttons held.
    repeat (3) @(negedge clk);
    check("reset_digits", {16'd0, cur_val(0)}, 32'h0000);
    check("reset_running", {31'd0, sw_if.RUNNING}, 32'd0);
    check("reset_en", {28'd0, sw_if.EN}, {28'd0, EN_LEAD_ZERO});
    check("reset_dp", {28'd0, sw_if.DP}, 32'h4);
    nrst = 1'b1;
    repeat (8) @(negedge clk);
    check("held_btn_no_start", {31'd0, sw_if.RUNNING}, 32'd0);
    check("held_btn_digits", {16'd0, cur_val(0)}, 32'h0000);
    check("held_btn_fast", {31'd0, fw_if.RUNNING}, 32'd0);
    sw_if.BTN_SS = 1'b0; sw_if.BTN_CLR = 1'b0;
    fw_if.BTN_SS = 1'b0; fw_if.BTN_CLR = 1'b0;
    repeat (4) @(negedge clk);
    check("release_idle", {31'd0, sw_if.RUNNING}, 32'd0);

    // Start: first increment CNTMAX+1 cycles after RUNNING rises.
    sw_if.BTN_SS = 1'b1;
    wait_run(0, 1'b1, "start_running");
    sw_if.BTN_SS = 1'b0;
    cycles_to_change(0, n);
    check("start_latency", n, 32'd10);
    check("first_count", {16'd0, cur_val(0)}, 32'h0001);

    // Carry from hundredths into tenths.
    wait_val(0, 16'h0009, 200, "reach_00_09");
    cycles_to_change(0, n);
    check("carry_latency", n, 32'd10);
    check("carry_00_10", {16'd0, cur_val(0)}, 32'h0010);

    // Stop at 12.34, hold, then resume.
    wait_val(0, 16'h1234, 20000, "reach_12_34");
    sw_if.BTN_SS = 1'b1;
    wait_run(0, 1'b0, "stop_running");
    sw_if.BTN_SS = 1'b0;
    repeat (20) @(negedge clk);
    check("stopped_hold", {16'd0, cur_val(0)}, 32'h1234);
    check("stopped_running", {31'd0, sw_if.RUNNING}, 32'd0);
    sw_if.BTN_SS = 1'b1;
    wait_run(0, 1'b1, "resume_running");
    sw_if.BTN_SS = 1'b0;
    cycles_to_change(0, n);
    check("resume_latency", n, 32'd10);
    check("resume_12_35", {16'd0, cur_val(0)}, 32'h1235);

    // Clear from RUN.
    sw_if.BTN_CLR = 1'b1;
    repeat (6) @(negedge clk);
    sw_if.BTN_CLR = 1'b0;
    check("clear_digits", {16'd0, cur_val(0)}, 32'h0000);
    check("clear_running", {31'd0, sw_if.RUNNING}, 32'd0);

    // Digit enables around the tens-of-seconds boundary.
    sw_if.BTN_SS = 1'b1;
    wait_run(0, 1'b1, "restart_running");
    sw_if.BTN_SS = 1'b0;
    wait_val(0, 16'h0999, 12000, "reach_09_99");
    check("en_09_99", {28'd0, sw_if.EN}, {28'd0, EN_LEAD_ZERO});
    wait_val(0, 16'h1000, 20, "reach_10_00");
    check("en_10_00", {28'd0, sw_if.EN}, 32'hF);

    // Both buttons rise together while running: clear wins.
    sw_if.BTN_SS = 1'b1; sw_if.BTN_CLR = 1'b1;
    repeat (6) @(negedge clk);
    sw_if.BTN_SS = 1'b0; sw_if.BTN_CLR = 1'b0;
    check("both_running", {31'd0, sw_if.RUNNING}, 32'd0);
    check("both_digits", {16'd0, cur_val(0)}, 32'h0000);

    // Saturation at 99.99 on the fast instance.
    fw_if.BTN_SS = 1'b1;
    wait_run(1, 1'b1, "fast_start");
    fw_if.BTN_SS = 1'b0;
    wait_val(1, 16'h9999, 12000, "reach_99_99");
    repeat (3) @(negedge clk);
    check("ovf_running", {31'd0, fw_if.RUNNING}, 32'd0);
    check("ovf_hold", {16'd0, cur_val(1)}, 32'h9999);
    fw_if.BTN_SS = 1'b1;
    repeat (6) @(negedge clk);
    fw_if.BTN_SS = 1'b0;
    repeat (3) @(negedge clk);
    check("ovf_ss_ignored", {31'd0, fw_if.RUNNING}, 32'd0);
    check("ovf_ss_hold", {16'd0, cur_val(1)}, 32'h9999);
    fw_if.BTN_CLR = 1'b1;
    repeat (6) @(negedge clk);
    fw_if.BTN_CLR = 1'b0;
    check("ovf_clear", {16'd0, cur_val(1)}, 32'h0000);
    check("ovf_clear_running", {31'd0, fw_if.RUNNING}, 32'd0);
    fw_if.BTN_SS = 1'b1;
    wait_run(1, 1'b1, "idle_after_clear");
    fw_if.BTN_SS = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
